// File: rtl/enc_serial_if.sv
// Handshake bundle between the register bank / output FIFO and the serial
// extended-Hamming encoder.
interface enc_serial_if #(
   parameter int MAX_CODEWORD_WIDTH = 32,
   parameter int MAX_INFO_WIDTH     = 26,
   parameter int AMBA_WORD          = 32
);
   logic                          in_valid;
   logic                          in_ready;
   logic [MAX_INFO_WIDTH-1:0]     data_in;
   logic [AMBA_WORD-1:0]          work_mod;
   logic                          out_valid;
   logic                          out_ready;
   logic [MAX_CODEWORD_WIDTH-1:0] data_out;
   logic                          err;

   modport master (
      output in_valid, data_in, work_mod, out_ready,
      input  in_ready, out_valid, data_out, err
   );

   modport slave (
      input  in_valid, data_in, work_mod, out_ready,
      output in_ready, out_valid, data_out, err
   );
endinterface

// File: rtl/enc_serial.sv
// Bit-serial extended-Hamming encoder. Walks the info bits one per clock,
// folding the matching parity-check column into an accumulator, then emits
// {info, parity} right-aligned with err flagging unsupported modes.
module enc_serial #(
   parameter int MAX_CODEWORD_WIDTH = 32,
   parameter int MAX_INFO_WIDTH     = 26,
   parameter int AMBA_WORD          = 32
) (
   input  logic        clk,
   input  logic        rst,
   enc_serial_if.slave io_bus
);
   localparam int P = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FIN, S_OUT} state_t;

   // Info length per mode.
   function automatic logic [4:0] k_of(input logic [1:0] mode);
      case (mode)
         2'd0:    k_of = 5'd4;
         2'd1:    k_of = 5'd11;
         2'd2:    k_of = 5'd26;
         default: k_of = 5'd4;
      endcase
   endfunction

   // Parity length per mode.
   function automatic logic [2:0] pm_of(input logic [1:0] mode);
      case (mode)
         2'd0:    pm_of = 3'd4;
         2'd1:    pm_of = 3'd5;
         2'd2:    pm_of = 3'd6;
         default: pm_of = 3'd4;
      endcase
   endfunction

   // Non-overall check rows; row r carries its identity bit at column r.
   function automatic logic [31:0] row_of(input logic [1:0] mode, input logic [2:0] r);
      row_of = 32'h0000_0000;
      case (mode)
         2'd0: begin
            case (r)
               3'd0:    row_of = 32'h0000_00B1;
               3'd1:    row_of = 32'h0000_00D2;
               3'd2:    row_of = 32'h0000_00E4;
               default: row_of = 32'h0000_0000;
            endcase
         end
         2'd1: begin
            case (r)
               3'd0:    row_of = 32'h0000_AB61;
               3'd1:    row_of = 32'h0000_CDA2;
               3'd2:    row_of = 32'h0000_F1C4;
               3'd3:    row_of = 32'h0000_FE08;
               default: row_of = 32'h0000_0000;
            endcase
         end
         2'd2: begin
            case (r)
               3'd0:    row_of = 32'hAAAB_56C1;
               3'd1:    row_of = 32'hCCCD_9B42;
               3'd2:    row_of = 32'hF0F1_E384;
               3'd3:    row_of = 32'hFF01_FC08;
               3'd4:    row_of = 32'hFFFE_0010;
               default: row_of = 32'h0000_0000;
            endcase
         end
         default: row_of = 32'h0000_0000;
      endcase
   endfunction

   // One H column restricted to the non-overall rows.
   function automatic logic [4:0] col_of(input logic [1:0] mode, input logic [5:0] col);
      logic [31:0] row;
      col_of = 5'd0;
      for (int r = 0; r < 5; r++) begin
         row       = row_of(mode, 3'(r));
         col_of[r] = row[col];
      end
   endfunction

   state_t                        r_state, w_state_nx;
   logic [MAX_INFO_WIDTH-1:0]     r_info, w_info_nx;
   logic [1:0]                    r_mode, w_mode_nx;
   logic [4:0]                    r_k, w_k_nx;
   logic [2:0]                    r_pm, w_pm_nx;
   logic [P-2:0]                  r_acc, w_acc_nx;
   logic                          r_ones, w_ones_nx;
   logic [4:0]                    r_cnt, w_cnt_nx;
   logic                          r_in_ready, r_out_valid, r_err, w_err_nx;
   logic [MAX_CODEWORD_WIDTH-1:0] r_dout, w_dout_nx;

   logic                          w_mode_ok;
   logic [1:0]                    w_req_mode;
   logic [MAX_INFO_WIDTH-1:0]     w_kmask;
   logic [4:0]                    w_col_all;
   logic [P-2:0]                  w_col;
   logic                          w_top;
   logic [5:0]                    w_parity;
   logic [31:0]                   w_cw;

   assign io_bus.in_ready  = r_in_ready;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.data_out  = r_dout;
   assign io_bus.err       = r_err;

   // Decode the requested mode and whether this build supports it.
   always_comb begin
      w_mode_ok  = 1'b0;
      w_req_mode = 2'd0;
      if (io_bus.work_mod == AMBA_WORD'(0)) begin
         w_mode_ok  = 1'b1;
         w_req_mode = 2'd0;
      end else if (io_bus.work_mod == AMBA_WORD'(1)) begin
         w_mode_ok  = (MAX_CODEWORD_WIDTH >= 16);
         w_req_mode = 2'd1;
      end else if (io_bus.work_mod == AMBA_WORD'(2)) begin
         w_mode_ok  = (MAX_CODEWORD_WIDTH == 32);
         w_req_mode = 2'd2;
      end else begin
         w_mode_ok  = 1'b0;
         w_req_mode = 2'd0;
      end
   end

   // Column lookup for the current info bit and final codeword assembly.
   always_comb begin
      w_kmask   = MAX_INFO_WIDTH'((32'd1 << k_of(w_req_mode)) - 32'd1);
      w_col_all = col_of(r_mode, 6'(r_pm) + 6'(r_cnt));
      w_col     = w_col_all[P-2:0];
      w_top     = r_ones ^ (^r_acc);
      w_parity  = 6'(r_acc) | (6'(w_top) << (r_pm - 3'd1));
      w_cw      = (32'(r_info) << r_pm) | 32'(w_parity);
   end

   // Next-state and datapath update for the IDLE/SHIFT/FIN/OUT sequence.
   always_comb begin
      w_state_nx = r_state;
      w_info_nx  = r_info;
      w_mode_nx  = r_mode;
      w_k_nx     = r_k;
      w_pm_nx    = r_pm;
      w_acc_nx   = r_acc;
      w_ones_nx  = r_ones;
      w_cnt_nx   = r_cnt;
      w_dout_nx  = r_dout;
      w_err_nx   = r_err;
      case (r_state)
         S_IDLE: begin
            if (io_bus.in_valid && r_in_ready) begin
               w_info_nx = io_bus.data_in & w_kmask;
               w_mode_nx = w_req_mode;
               w_k_nx    = k_of(w_req_mode);
               w_pm_nx   = pm_of(w_req_mode);
               w_acc_nx  = '0;
               w_ones_nx = 1'b0;
               w_cnt_nx  = 5'd0;
               if (w_mode_ok) begin
                  w_state_nx = S_SHIFT;
               end else begin
                  w_state_nx = S_OUT;
                  w_dout_nx  = '0;
                  w_err_nx   = 1'b1;
               end
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (r_info[r_cnt]) begin
               w_acc_nx  = r_acc ^ w_col;
               w_ones_nx = ~r_ones;
            end else begin
               w_acc_nx  = r_acc;
            end
            w_cnt_nx = r_cnt + 5'd1;
            if (r_cnt == (r_k - 5'd1)) begin
               w_state_nx = S_FIN;
            end else begin
               w_state_nx = S_SHIFT;
            end
         end
         S_FIN: begin
            w_dout_nx  = MAX_CODEWORD_WIDTH'(w_cw);
            w_err_nx   = 1'b0;
            w_state_nx = S_OUT;
         end
         S_OUT: begin
            if (io_bus.out_ready) begin
               w_state_nx = S_IDLE;
            end else begin
               w_state_nx = S_OUT;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // State, datapath and output registers; reset aborts any word in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_info      <= '0;
         r_mode      <= 2'd0;
         r_k         <= 5'd0;
         r_pm        <= 3'd0;
         r_acc       <= '0;
         r_ones      <= 1'b0;
         r_cnt       <= 5'd0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_dout      <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_info      <= w_info_nx;
         r_mode      <= w_mode_nx;
         r_k         <= w_k_nx;
         r_pm        <= w_pm_nx;
         r_acc       <= w_acc_nx;
         r_ones      <= w_ones_nx;
         r_cnt       <= w_cnt_nx;
         r_in_ready  <= (w_state_nx == S_IDLE);
         r_out_valid <= (w_state_nx == S_OUT);
         r_dout      <= w_dout_nx;
         r_err       <= w_err_nx;
      end
   end
endmodule

// File: tb/tb_enc_serial.sv
// Self-checking bench for enc_serial: directed vectors, random words with
// random backpressure, invalid modes, ignored in_valid, narrow build, reset.
module tb_enc_serial;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   logic [31:0] last_dout;

   always #5 clk = ~clk;

   enc_serial_if #(.MAX_CODEWORD_WIDTH(32), .MAX_INFO_WIDTH(26), .AMBA_WORD(32)) b();
   enc_serial_if #(.MAX_CODEWORD_WIDTH(8),  .MAX_INFO_WIDTH(4),  .AMBA_WORD(32)) b8();

   enc_serial #(.MAX_CODEWORD_WIDTH(32), .MAX_INFO_WIDTH(26), .AMBA_WORD(32)) dut (
      .clk(clk), .rst(rst), .io_bus(b));
   enc_serial #(.MAX_CODEWORD_WIDTH(8), .MAX_INFO_WIDTH(4), .AMBA_WORD(32)) dut8 (
      .clk(clk), .rst(rst), .io_bus(b8));

   function automatic int pm_of(input int m);
      return (m == 0) ? 4 : (m == 1) ? 5 : 6;
   endfunction

   function automatic int k_of(input int m);
      return (m == 0) ? 4 : (m == 1) ? 11 : 26;
   endfunction

   // H rows, top (overall parity) row first, as listed for each mode.
   function automatic logic [31:0] hrow(input int m, input int j);
      logic [31:0] t [6];
      case (m)
         0: t = '{32'hFF, 32'hE4, 32'hD2, 32'hB1, 32'h0, 32'h0};
         1: t = '{32'hFFFF, 32'hFE08, 32'hF1C4, 32'hCDA2, 32'hAB61, 32'h0};
         2: t = '{32'hFFFFFFFF, 32'hFFFE0010, 32'hFF01FC08, 32'hF0F1E384,
                  32'hCCCD9B42, 32'hAAAB56C1};
         default: t = '{default: 32'h0};
      endcase
      return t[j];
   endfunction

   // Codeword from whole-vector parity: each check row over the shifted info,
   // then overall parity makes the total weight even.
   function automatic logic [31:0] ref_cw(input int m, input logic [25:0] info);
      logic [31:0] base, cw;
      int pm;
      pm   = pm_of(m);
      base = (32'(info) & ((32'd1 << k_of(m)) - 32'd1)) << pm;
      cw   = base;
      for (int r = 0; r < pm - 1; r++) cw[r] = ^(hrow(m, pm - 1 - r) & base);
      cw[pm-1] = ^cw;
      return cw;
   endfunction

   function automatic logic [5:0] syndrome(input int m, input logic [31:0] cw);
      logic [5:0] s;
      s = 6'd0;
      for (int j = 0; j < pm_of(m); j++) s[j] = ^(hrow(m, j) & cw);
      return s;
   endfunction

   // One word through the wide DUT; junk=1 pulses in_valid while busy.
   task automatic run_word(input logic [31:0] mode, input logic [25:0] info, input bit junk);
      logic [31:0] exp_cw, d0;
      logic        exp_err;
      int          exp_lat, t;
      bit          ok, done;
      ok      = (mode < 32'd3);
      exp_cw  = ok ? ref_cw(int'(mode), info) : 32'h0;
      exp_err = !ok;
      exp_lat = ok ? k_of(int'(mode)) + 1 : 1;
      t = 0;
      while (b.in_ready !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
      n_vec++;
      if (b.in_ready !== 1'b1) begin
         n_err++; $display("FAIL in_ready_wait got %b want 1", b.in_ready); return;
      end
      b.in_valid = 1'b1; b.data_in = info; b.work_mod = mode; b.out_ready = 1'b0;
      @(posedge clk); #1;
      b.in_valid = junk; b.data_in = 26'($urandom); b.work_mod = 32'($urandom_range(0, 3));
      t = 0;
      while (b.out_valid !== 1'b1 && t < 60) begin
         if (junk) begin
            n_vec++;
            if (b.in_ready !== 1'b0) begin
               n_err++; $display("FAIL in_ready_busy got %b want 0 t=%0d", b.in_ready, t);
            end
         end
         @(posedge clk); #1; t++;
      end
      b.in_valid = 1'b0;
      n_vec++;
      if (b.out_valid !== 1'b1 || (ok ? (t != exp_lat) : (t > 1))) begin
         n_err++; $display("FAIL latency mode=%0d got %0d edges want %0d", mode, t, exp_lat);
         if (b.out_valid !== 1'b1) return;
      end
      if (!ok && t == 0) begin
         @(posedge clk); #1;
         n_vec++;
         if (b.out_valid !== 1'b1) begin
            n_err++; $display("FAIL err_valid_e1 got %b want 1", b.out_valid);
         end
      end
      d0 = b.data_out; last_dout = d0;
      n_vec++;
      if (d0 !== exp_cw || b.err !== exp_err) begin
         n_err++;
         $display("FAIL codeword mode=%0d info=%h got %h/%b want %h/%b",
                  mode, info, d0, b.err, exp_cw, exp_err);
      end
      if (ok) begin
         n_vec++;
         if (syndrome(int'(mode), d0) !== 6'd0) begin
            n_err++; $display("FAIL syndrome got %h want 00", syndrome(int'(mode), d0));
         end
      end
      done = 1'b0; t = 0;
      while (!done) begin
         b.out_ready = ($urandom_range(0, 3) == 0) || (t > 20);
         @(posedge clk);
         done = b.out_ready;
         #1; t++;
         if (!done) begin
            n_vec++;
            if (b.out_valid !== 1'b1 || b.data_out !== d0 || b.err !== exp_err) begin
               n_err++;
               $display("FAIL hold got %b/%h want 1/%h", b.out_valid, b.data_out, d0);
            end
         end
      end
      b.out_ready = 1'b0;
      n_vec++;
      if (b.out_valid !== 1'b0 || b.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL post_handshake got v=%b r=%b want v=0 r=1", b.out_valid, b.in_ready);
      end
   endtask

   task automatic test_reset();
      #1;
      n_vec++;
      if (b.in_ready !== 1'b0 || b.out_valid !== 1'b0 || b.data_out !== 32'h0 || b.err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state got r=%b v=%b d=%h e=%b want 0/0/0/0",
                  b.in_ready, b.out_valid, b.data_out, b.err);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      #1;
      n_vec++;
      if (b.in_ready !== 1'b0) begin
         n_err++; $display("FAIL ready_before_edge got %b want 0", b.in_ready);
      end
      @(posedge clk); #1;
      n_vec++;
      if (b.in_ready !== 1'b1 || b.out_valid !== 1'b0) begin
         n_err++; $display("FAIL ready_after_release got r=%b v=%b want 1/0", b.in_ready, b.out_valid);
      end
   endtask

   task automatic test_directed();
      run_word(32'd0, 26'hB, 1'b0);
      n_vec++;
      if (last_dout !== 32'h0000_00B1) begin n_err++; $display("FAIL m0_B got %h want 000000b1", last_dout); end
      run_word(32'd0, 26'hF, 1'b0);
      n_vec++;
      if (last_dout !== 32'h0000_00FF) begin n_err++; $display("FAIL m0_F got %h want 000000ff", last_dout); end
      run_word(32'd2, 26'h1, 1'b0);
      n_vec++;
      if (last_dout !== 32'h0000_0063) begin n_err++; $display("FAIL m2_1 got %h want 00000063", last_dout); end
      run_word(32'd2, 26'h0, 1'b0);
      n_vec++;
      if (last_dout !== 32'h0) begin n_err++; $display("FAIL m2_0 got %h want 00000000", last_dout); end
   endtask

   task automatic test_invalid();
      run_word(32'd3, 26'h3FF_FFFF, 1'b0);
      run_word(32'hFFFF_FFFF, 26'($urandom), 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) run_word(32'($urandom_range(0, 2)), 26'($urandom), 1'b0);
   endtask

   task automatic test_shift_ignore();
      run_word(32'd2, 26'($urandom), 1'b1);
      run_word(32'd1, 26'($urandom), 1'b1);
      run_word(32'd0, 26'h5, 1'b0);
   endtask

   // 8-bit build: mode 1 is unsupported, mode 0 still encodes.
   task automatic test_narrow_build();
      int t;
      for (int w = 0; w < 2; w++) begin
         t = 0;
         while (b8.in_ready !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
         b8.in_valid = 1'b1; b8.work_mod = (w == 0) ? 32'd1 : 32'd0; b8.data_in = 4'hB;
         @(posedge clk); #1;
         b8.in_valid = 1'b0;
         t = 0;
         while (b8.out_valid !== 1'b1 && t < 40) begin @(posedge clk); #1; t++; end
         n_vec++;
         if (w == 0 && (t > 1 || b8.data_out !== 8'h00 || b8.err !== 1'b1)) begin
            n_err++; $display("FAIL narrow_m1 got t=%0d d=%h e=%b want t<=1 d=00 e=1", t, b8.data_out, b8.err);
         end
         if (w == 1 && (t != 5 || b8.data_out !== 8'hB1 || b8.err !== 1'b0)) begin
            n_err++; $display("FAIL narrow_m0 got t=%0d d=%h e=%b want t=5 d=b1 e=0", t, b8.data_out, b8.err);
         end
         b8.out_ready = 1'b1;
         @(posedge clk); #1;
         b8.out_ready = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      int t;
      run_word(32'd0, 26'hF, 1'b0);
      t = 0;
      while (b.in_ready !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
      b.in_valid = 1'b1; b.work_mod = 32'd2; b.data_in = 26'($urandom);
      @(posedge clk); #1;
      b.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1; rst = 1'b0; #1;
      n_vec++;
      if (b.out_valid !== 1'b0 || b.data_out !== 32'h0 || b.in_ready !== 1'b0 || b.err !== 1'b0) begin
         n_err++; $display("FAIL reset_mid got v=%b d=%h r=%b want 0/0/0", b.out_valid, b.data_out, b.in_ready);
      end
      repeat (2) @(posedge clk);
      #2; rst = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         n_vec++;
         if (b.out_valid !== 1'b0) begin
            n_err++; $display("FAIL aborted_word got %b want 0 cycle=%0d", b.out_valid, i);
         end
      end
      run_word(32'd0, 26'hB, 1'b0);
      n_vec++;
      if (last_dout !== 32'h0000_00B1) begin n_err++; $display("FAIL after_reset got %h want 000000b1", last_dout); end
   endtask

   initial begin
      b.in_valid = 1'b0;  b.data_in = '0;  b.work_mod = '0;  b.out_ready = 1'b0;
      b8.in_valid = 1'b0; b8.data_in = '0; b8.work_mod = '0; b8.out_ready = 1'b0;
      last_dout = 32'h0;
      test_reset();
      test_directed();
      test_invalid();
      test_random();
      test_shift_ignore();
      test_narrow_build();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
